icache_direct: RTL and testbench
================================

# icache_direct

Direct-mapped instruction cache between the IF stage and the byte-wide memory controller. IF registers a word-aligned fetch address into `raddr_i` and samples `hit_o`/`inst_o` on the next cycle. On a miss, IF fetches the word byte-by-byte through mem_ctrl and writes the assembled word back through the write port. The cache never touches memory itself. It holds valid/tag/data arrays, supports a whole-cache flush (fence.i, program reload), and optionally counts hits and misses.

## Interface
- `INDEX_BITS`, default 7: line-index width; 2^INDEX_BITS one-word lines (128).
- `ADDR_WIDTH`, default 17: significant physical address bits.
  - Tag = `addr[ADDR_WIDTH-1 : INDEX_BITS+2]`; index = `addr[INDEX_BITS+1 : 2]`; `addr[1:0]` ignored.
- `clk`  in  1  clock, all state updates on posedge.
- `rst`  in  1  reset rst, synchronous, active-high; clock clk.
- `raddr_i`  in  32  lookup address; driven from an IF register.
- `hit_o`  out  1  combinational: valid[idx] && tag match && !rst.
- `inst_o`  out  32  combinational data of indexed line; don't-care when `hit_o`=0.
- `rvalid_i`  in  1  IF consumes a lookup result this cycle; used only by the performance counters.
- `we_i`  in  1  fill strobe, one cycle per assembled word.
- `waddr_i`  in  32  fill address.
- `wdata_i`  in  32  fill word, little-endian as assembled by IF.
- `flush_i`  in  1  invalidate all lines at the next posedge.
- `hit_cnt_o`  out  32  lookups with rvalid_i && hit_o (macro only, else constant 0).
- `miss_cnt_o`  out  32  lookups with rvalid_i && !hit_o (macro only, else constant 0).

## Operation
- Storage:
  - `valid[2^INDEX_BITS]` flops.
  - `tag[2^INDEX_BITS]` of width ADDR_WIDTH-INDEX_BITS-2.
  - `data[2^INDEX_BITS]` of 32 bits.
  - Only valid bits and counters are reset; tag and data arrays are not.
- Read path is purely combinational on current array contents. There is no read state and no stall output.
- Fill: on posedge with `we_i`=1 and `flush_i`=0:
  - `valid[widx]` <= 1, `tag[widx]` <= wtag, `data[widx]` <= `wdata_i`.
  - Any previous line at that index is overwritten unconditionally (no replacement choice).
- Flush: on posedge with `flush_i`=1, all valid bits clear in that single cycle.
- Priority at each posedge: `rst` > `flush_i` > `we_i`.
  - A fill coinciding with a flush is discarded.
- Read/write same cycle, same index: `hit_o`/`inst_o` reflect pre-write contents (no forwarding). New data is visible from the next cycle.
- Fill to an index whose valid line has a different tag replaces it. The old address misses afterwards.
- Upper address bits above ADDR_WIDTH are ignored, so aliased addresses hit.
- Counters: 32-bit, increment by 1 on posedge when `rvalid_i`=1, selecting hit or miss per `hit_o`.
  - Wrap 0xFFFFFFFF -> 0.
  - Not cleared by flush.
  - Cleared by rst.

## Timing
- Reset values:
  - `hit_o`=0 (forced while rst=1 and, after reset, because all lines are invalid).
  - `inst_o`=undefined/don't-care.
  - `hit_cnt_o`=0, `miss_cnt_o`=0, all valid=0.
- Lookup latency 0 cycles from `raddr_i`. IF registers the address in cycle N and samples the hit in cycle N+1, using the combinational output during N+1.
- Fill latency: `we_i` in cycle N -> line hits for lookups in cycle N+1 onward.
- Flush: `flush_i` in cycle N -> every lookup misses from cycle N+1 onward.
- Reset mid-fill (`rst` and `we_i` together): no line becomes valid.
- Counter outputs are registered and reflect lookups up to the previous cycle.

## Configuration
- `ICACHE_PERF_CNT_EN` defined: hit/miss counters instantiated as above.
- Not defined: no counter flops; `hit_cnt_o`/`miss_cnt_o` tied to 32'h0; `rvalid_i` ignored. Cache behaviour is otherwise identical.

## Test plan
- Reset, then `raddr_i`=0x0000_0000 -> `hit_o`=0. Counters read 0.
- Fill: `we_i`=1, `waddr_i`=0x104, `wdata_i`=0x0000_0013. Next cycle `raddr_i`=0x104 -> `hit_o`=1, `inst_o`=0x0000_0013.
- Conflict: fill 0x104 = 0x13, then 0x304 = 0x00A00093 (same index 0x41) -> 0x104 misses; 0x304 hits with 0x00A00093.
- Same-cycle hazard: `raddr_i`=0x208 and fill 0x208 = 0xDEADBEEF in the same cycle on an empty line -> `hit_o`=0 that cycle, 1 with 0xDEADBEEF next cycle.
- Flush: fill 0x10, 0x14, then `flush_i`=1 -> both miss. `flush_i` and fill 0x18 in the same cycle -> 0x18 misses.
- Counters (macro on): three `rvalid_i` lookups (hit, hit, miss) -> `hit_cnt_o`=2, `miss_cnt_o`=1. Preload `hit_cnt_o`=0xFFFFFFFF via force, one hit -> 0.

Source files
------------

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped, one-word-per-line instruction cache.
// The lookup is purely combinational on the current array contents.
// Fills come from IF after it has assembled a word through mem_ctrl.
// Optional hit/miss performance counters are built only when the macro
// ICACHE_PERF_CNT_EN is defined. Otherwise both counter outputs are tied to zero.
module icache_direct #(
   parameter int INDEX_BITS = 7,
   parameter int ADDR_WIDTH = 17
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] raddr_i,
   output logic        hit_o,
   output logic [31:0] inst_o,
   input  logic        rvalid_i,
   input  logic        we_i,
   input  logic [31:0] waddr_i,
   input  logic [31:0] wdata_i,
   input  logic        flush_i,
   output logic [31:0] hit_cnt_o,
   output logic [31:0] miss_cnt_o
);

   localparam int LINES     = 1 << INDEX_BITS;
   localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_BITS - 2;

   logic [LINES-1:0]     valid;
   logic [TAG_WIDTH-1:0] tag_arr  [LINES];
   logic [31:0]          data_arr [LINES];

   logic [INDEX_BITS-1:0] ridx;
   logic [INDEX_BITS-1:0] widx;
   logic [TAG_WIDTH-1:0]  rtag;
   logic [TAG_WIDTH-1:0]  wtag;
   logic                  fill_en;

   assign ridx    = raddr_i[INDEX_BITS+1:2];
   assign rtag    = raddr_i[ADDR_WIDTH-1:INDEX_BITS+2];
   assign widx    = waddr_i[INDEX_BITS+1:2];
   assign wtag    = waddr_i[ADDR_WIDTH-1:INDEX_BITS+2];
   assign fill_en = we_i && !flush_i && !rst;

   // Lookup reads the arrays as they stand, so a same-cycle fill is not forwarded.
   assign hit_o  = valid[ridx] && (tag_arr[ridx] == rtag) && !rst;
   assign inst_o = data_arr[ridx];

   // Valid bits: reset beats flush, and flush beats fill.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= '0;
      end else if (flush_i) begin
         valid <= '0;
      end else if (we_i) begin
         valid[widx] <= 1'b1;
      end
   end

   // Tag and data arrays are not reset; a fill overwrites whatever line sits at the index.
   always_ff @(posedge clk) begin
      if (fill_en) begin
         tag_arr[widx]  <= wtag;
         data_arr[widx] <= wdata_i;
      end
   end

`ifdef ICACHE_PERF_CNT_EN
   logic [31:0] hit_cnt_q;
   logic [31:0] miss_cnt_q;

   // Count each consumed lookup as a hit or a miss; the counters survive a flush and wrap naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else if (rvalid_i) begin
         if (hit_o) begin
            hit_cnt_q <= hit_cnt_q + 32'd1;
         end else begin
            miss_cnt_q <= miss_cnt_q + 32'd1;
         end
      end
   end

   assign hit_cnt_o  = hit_cnt_q;
   assign miss_cnt_o = miss_cnt_q;

   logic unused_bits;
   assign unused_bits = ^{raddr_i[31:ADDR_WIDTH], raddr_i[1:0],
                          waddr_i[31:ADDR_WIDTH], waddr_i[1:0]};
`else
   assign hit_cnt_o  = 32'h0;
   assign miss_cnt_o = 32'h0;

   logic unused_bits;
   assign unused_bits = ^{raddr_i[31:ADDR_WIDTH], raddr_i[1:0],
                          waddr_i[31:ADDR_WIDTH], waddr_i[1:0], rvalid_i};
`endif

endmodule

// File: tb/tb_icache_direct.sv
// tb_icache_direct: directed self-checking bench for icache_direct.
// Inputs change on the falling edge.
// Combinational outputs are sampled 1 time unit later, well away from the rising edge.
module tb_icache_direct;

   logic        clk;
   logic        rst;
   logic [31:0] raddr_i;
   logic        hit_o;
   logic [31:0] inst_o;
   logic        rvalid_i;
   logic        we_i;
   logic [31:0] waddr_i;
   logic [31:0] wdata_i;
   logic        flush_i;
   logic [31:0] hit_cnt_o;
   logic [31:0] miss_cnt_o;

   int checks = 0;
   int errors = 0;

   icache_direct dut (
      .clk        (clk),
      .rst        (rst),
      .raddr_i    (raddr_i),
      .hit_o      (hit_o),
      .inst_o     (inst_o),
      .rvalid_i   (rvalid_i),
      .we_i       (we_i),
      .waddr_i    (waddr_i),
      .wdata_i    (wdata_i),
      .flush_i    (flush_i),
      .hit_cnt_o  (hit_cnt_o),
      .miss_cnt_o (miss_cnt_o)
   );

   // Free-running clock with a 10-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so the run can never hang.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Wait for the next falling edge, then drive every input for the coming cycle.
   task automatic apply_stimulus(input logic r, input logic we, input logic fl, input logic rv,
                                 input logic [31:0] ra, input logic [31:0] wa,
                                 input logic [31:0] wd);
      @(negedge clk);
      rst      = r;
      we_i     = we;
      flush_i  = fl;
      rvalid_i = rv;
      raddr_i  = ra;
      waddr_i  = wa;
      wdata_i  = wd;
      #1;
   endtask

   // Compare one observed value against its expected value.
   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Directed sequence with hand-computed expectations.
   initial begin
      logic [31:0] exp_hits;
      logic [31:0] exp_miss;
      logic [31:0] exp_wrap;
`ifdef ICACHE_PERF_CNT_EN
      exp_hits = 32'd2;
      exp_miss = 32'd1;
      exp_wrap = 32'hFFFF_FFFF;
`else
      exp_hits = 32'd0;
      exp_miss = 32'd0;
      exp_wrap = 32'd0;
`endif
      rst = 1'b1; we_i = 1'b0; flush_i = 1'b0; rvalid_i = 1'b0;
      raddr_i = '0; waddr_i = '0; wdata_i = '0;

      // hit_o is forced low while reset is asserted
      apply_stimulus(1, 0, 0, 0, 32'h0, 32'h0, 32'h0);
      check_output("hit_in_reset", {31'b0, hit_o}, 32'd0);
      apply_stimulus(1, 0, 0, 0, 32'h0, 32'h0, 32'h0);

      // After reset: empty cache and cleared counters
      apply_stimulus(0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
      check_output("reset_hit", {31'b0, hit_o}, 32'd0);
      check_output("reset_hit_cnt", hit_cnt_o, 32'd0);
      check_output("reset_miss_cnt", miss_cnt_o, 32'd0);

      // Fill 0x104 while looking it up: pre-write miss, then a hit
      apply_stimulus(0, 1, 0, 0, 32'h104, 32'h104, 32'h0000_0013);
      check_output("fill104_same_cycle", {31'b0, hit_o}, 32'd0);
      apply_stimulus(0, 0, 0, 0, 32'h104, 32'h0, 32'h0);
      check_output("fill104_hit", {31'b0, hit_o}, 32'd1);
      check_output("fill104_data", inst_o, 32'h0000_0013);

      // Conflict: 0x304 shares index 0x41 with 0x104 and replaces it
      apply_stimulus(0, 1, 0, 0, 32'h104, 32'h304, 32'h00A0_0093);
      check_output("conflict_old_still", {31'b0, hit_o}, 32'd1);
      apply_stimulus(0, 0, 0, 0, 32'h104, 32'h0, 32'h0);
      check_output("conflict_old_miss", {31'b0, hit_o}, 32'd0);
      apply_stimulus(0, 0, 0, 0, 32'h304, 32'h0, 32'h0);
      check_output("conflict_new_hit", {31'b0, hit_o}, 32'd1);
      check_output("conflict_new_data", inst_o, 32'h00A0_0093);

      // Address bits above bit 16 are ignored, so aliases hit
      apply_stimulus(0, 0, 0, 0, 32'h0002_0304, 32'h0, 32'h0);
      check_output("alias_20304", {31'b0, hit_o}, 32'd1);
      apply_stimulus(0, 0, 0, 0, 32'hFFFE_0306, 32'h0, 32'h0);
      check_output("alias_fffe0306", {31'b0, hit_o}, 32'd1);

      // Same-cycle hazard on an empty line
      apply_stimulus(0, 1, 0, 0, 32'h208, 32'h208, 32'hDEAD_BEEF);
      check_output("hazard_same", {31'b0, hit_o}, 32'd0);
      apply_stimulus(0, 0, 0, 0, 32'h208, 32'h0, 32'h0);
      check_output("hazard_next_hit", {31'b0, hit_o}, 32'd1);
      check_output("hazard_next_data", inst_o, 32'hDEAD_BEEF);

      // Flush: fill 0x10 and 0x14, then flush
      apply_stimulus(0, 1, 0, 0, 32'h0, 32'h10, 32'h1111_0010);
      apply_stimulus(0, 1, 0, 0, 32'h10, 32'h14, 32'h1111_0014);
      check_output("pre_flush_10", {31'b0, hit_o}, 32'd1);
      apply_stimulus(0, 0, 1, 0, 32'h14, 32'h0, 32'h0);
      check_output("pre_flush_14", {31'b0, hit_o}, 32'd1);
      apply_stimulus(0, 0, 0, 0, 32'h10, 32'h0, 32'h0);
      check_output("flush_10_miss", {31'b0, hit_o}, 32'd0);
      apply_stimulus(0, 0, 0, 0, 32'h14, 32'h0, 32'h0);
      check_output("flush_14_miss", {31'b0, hit_o}, 32'd0);
      apply_stimulus(0, 0, 0, 0, 32'h304, 32'h0, 32'h0);
      check_output("flush_304_miss", {31'b0, hit_o}, 32'd0);

      // A fill coinciding with a flush is discarded
      apply_stimulus(0, 1, 1, 0, 32'h18, 32'h18, 32'h1111_0018);
      apply_stimulus(0, 0, 0, 0, 32'h18, 32'h0, 32'h0);
      check_output("flush_fill_18_miss", {31'b0, hit_o}, 32'd0);

      // Reset mid-fill: refill 0x304, then assert rst together with a fill of 0x1C
      apply_stimulus(0, 1, 0, 0, 32'h0, 32'h304, 32'h00A0_0093);
      apply_stimulus(1, 1, 0, 0, 32'h304, 32'h1C, 32'h1111_001C);
      check_output("rst_forces_miss", {31'b0, hit_o}, 32'd0);
      apply_stimulus(0, 0, 0, 0, 32'h1C, 32'h0, 32'h0);
      check_output("rst_fill_1c_miss", {31'b0, hit_o}, 32'd0);
      apply_stimulus(0, 0, 0, 0, 32'h304, 32'h0, 32'h0);
      check_output("rst_clears_304", {31'b0, hit_o}, 32'd0);

      // Counters: hit, hit, miss
      apply_stimulus(0, 1, 0, 0, 32'h0, 32'h40, 32'h1234_5678);
      apply_stimulus(0, 0, 0, 1, 32'h40, 32'h0, 32'h0);
      check_output("cnt_lookup1_hit", {31'b0, hit_o}, 32'd1);
      apply_stimulus(0, 0, 0, 1, 32'h40, 32'h0, 32'h0);
      apply_stimulus(0, 0, 0, 1, 32'h44, 32'h0, 32'h0);
      check_output("cnt_lookup3_miss", {31'b0, hit_o}, 32'd0);
      apply_stimulus(0, 0, 0, 0, 32'h40, 32'h0, 32'h0);
      check_output("hit_cnt", hit_cnt_o, exp_hits);
      check_output("miss_cnt", miss_cnt_o, exp_miss);

      // Counters are not cleared by flush
      apply_stimulus(0, 0, 1, 0, 32'h40, 32'h0, 32'h0);
      apply_stimulus(0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
      check_output("hit_cnt_after_flush", hit_cnt_o, exp_hits);

      // Wrap: preload 0xFFFFFFFF, then one hit wraps the counter to 0
      apply_stimulus(0, 1, 0, 0, 32'h0, 32'h40, 32'h1234_5678);
`ifdef ICACHE_PERF_CNT_EN
      force dut.hit_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.hit_cnt_q;
`endif
      check_output("wrap_preload", hit_cnt_o, exp_wrap);
      apply_stimulus(0, 0, 0, 1, 32'h40, 32'h0, 32'h0);
      check_output("wrap_lookup_hit", {31'b0, hit_o}, 32'd1);
      apply_stimulus(0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
      check_output("wrap_hit_cnt", hit_cnt_o, 32'd0);
      check_output("wrap_miss_cnt", miss_cnt_o, exp_miss);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
